// File: rtl/data_arith_narrow.sv
`default_nettype none
// ============================================================================
// Module   : data_arith_narrow
// Purpose  : Pipelined multi-lane width reducer (wrap/saturate, signed or
//            unsigned) with per-lane, sticky and counted overflow status.
// Revision : 1.0 - initial release
// ============================================================================

package data_arith_narrow_pkg;
    typedef struct packed {
        logic Clock;
        logic Reset;
    } Data_Control_Control_T;

    typedef enum logic {
        Unsigned = 1'b0,
        Signed   = 1'b1
    } Data_Arith_SignedUnsigned_T;
endpackage

module data_arith_narrow
    import data_arith_narrow_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  Data_Control_Control_T          ctrl,
    input  logic [DEPTH-1:0][IN_W-1:0]     in,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  Data_Arith_SignedUnsigned_T     sign,
    input  logic                           saturate,
    output logic [DEPTH-1:0][OUT_W-1:0]    out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DEPTH-1:0]               ovf,
    output logic [DEPTH-1:0]               ovf_sticky,
    output logic [CNT_W-1:0]               ovf_count,
    input  logic                           clear
);

    localparam int              C_K       = IN_W - OUT_W;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic                        w_clk;
    logic                        w_rst;
    logic                        w_accept;
    logic                        w_handoff;
    logic [DEPTH-1:0]            w_ovf_new;
    logic [DEPTH-1:0][OUT_W-1:0] w_res;

    logic [DEPTH-1:0][OUT_W-1:0] out_q, out_d;
    logic [DEPTH-1:0]            ovf_q, ovf_d;
    logic                        out_valid_q, out_valid_d;
    logic [DEPTH-1:0]            sticky_q, sticky_d;
    logic [CNT_W-1:0]            count_q, count_d;

    assign w_clk = ctrl.Clock;
    assign w_rst = ctrl.Reset;

    // No skid buffer: readiness follows the consumer combinationally.
    assign in_ready  = !w_rst && (!out_valid_q || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_handoff = out_valid_q && out_ready;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
        logic [C_K:0]     w_top;
        logic             w_ovf_s;
        logic             w_ovf_u;
        logic [OUT_W-1:0] w_sat;

        assign w_top   = in[gi][IN_W-1 -: C_K+1];
        // Signed fits only if the dropped bits all replicate the new sign bit.
        assign w_ovf_s = !((&w_top) || !(|w_top));
        assign w_ovf_u = |w_top[C_K:1];
        assign w_ovf_new[gi] = (sign == Signed) ? w_ovf_s : w_ovf_u;
        assign w_sat = (sign == Signed)
                     ? {in[gi][IN_W-1], {(OUT_W-1){~in[gi][IN_W-1]}}}
                     : {OUT_W{1'b1}};
        assign w_res[gi] = (saturate && w_ovf_new[gi]) ? w_sat : in[gi][OUT_W-1:0];
    end

    always_comb begin
        out_d       = out_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        sticky_d    = clear ? '0 : sticky_q;
        count_d     = clear ? '0 : count_q;

        if (w_accept) begin
            out_d       = w_res;
            ovf_d       = w_ovf_new;
            out_valid_d = 1'b1;
            sticky_d    = sticky_d | w_ovf_new;
            if ((|w_ovf_new) && (count_d != C_CNT_MAX)) begin
                count_d = count_d + 1'b1;
            end
        end else if (w_handoff) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            out_q       <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            sticky_q    <= '0;
            count_q     <= '0;
        end else begin
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
        end
    end

    assign out        = out_q;
    assign ovf        = ovf_q;
    assign out_valid  = out_valid_q;
    assign ovf_sticky = sticky_q;
    assign ovf_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_data_arith_narrow.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_arith_narrow
// Purpose  : Directed self-checking bench for data_arith_narrow
//            (IN_W=8, OUT_W=4, DEPTH=2, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================

module tb_data_arith_narrow;
    import data_arith_narrow_pkg::*;

    logic                        clk;
    logic                        rst;
    Data_Control_Control_T       ctrl;
    logic [1:0][7:0]             din;
    logic                        in_valid;
    logic                        in_ready;
    Data_Arith_SignedUnsigned_T  sign;
    logic                        saturate;
    logic [1:0][3:0]             dout;
    logic                        out_valid;
    logic                        out_ready;
    logic [1:0]                  ovf;
    logic [1:0]                  ovf_sticky;
    logic [1:0]                  ovf_count;
    logic                        clear;

    int total = 0;
    int bad   = 0;

    assign ctrl.Clock = clk;
    assign ctrl.Reset = rst;

    data_arith_narrow #(
        .IN_W (8),
        .OUT_W(4),
        .DEPTH(2),
        .CNT_W(2)
    ) dut (
        .ctrl      (ctrl),
        .in        (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .saturate  (saturate),
        .out       (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .ovf_sticky(ovf_sticky),
        .ovf_count (ovf_count),
        .clear     (clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] e_out, input logic [1:0] e_ovf,
                             input logic e_vld, input logic [1:0] e_sticky, input logic [1:0] e_cnt);
        chk({tag, ".out"},    32'(dout),       32'(e_out));
        chk({tag, ".ovf"},    32'(ovf),        32'(e_ovf));
        chk({tag, ".valid"},  32'(out_valid),  32'(e_vld));
        chk({tag, ".sticky"}, 32'(ovf_sticky), 32'(e_sticky));
        chk({tag, ".count"},  32'(ovf_count),  32'(e_cnt));
    endtask

    initial begin
        logic [1:0] cnt_exp [5];
        cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst       = 1'b1;
        in_valid  = 1'b1;
        din[0]    = 8'h55;
        din[1]    = 8'h55;
        sign      = Signed;
        saturate  = 1'b1;
        out_ready = 1'b1;
        clear     = 1'b0;

        // Reset held two cycles with in_valid asserted
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk_state("reset", 8'h00, 2'b00, 1'b0, 2'b00, 2'd0);
            chk("reset.in_ready", 32'(in_ready), 32'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_reset.in_ready", 32'(in_ready), 32'd1);

        // Signed saturate, no overflow
        din[0] = 8'hF9; din[1] = 8'h05; in_valid = 1'b1;
        sign = Signed; saturate = 1'b1;
        cyc();
        chk_state("sat_ok", 8'h59, 2'b00, 1'b1, 2'b00, 2'd0);

        // Signed saturate, negative lane0 / positive lane1 overflow
        din[0] = 8'h80; din[1] = 8'h7F;
        cyc();
        chk_state("sat_ovf", 8'h78, 2'b11, 1'b1, 2'b11, 2'd1);

        // Unsigned wrap, only lane 0 overflows
        din[0] = 8'h1A; din[1] = 8'h0F; sign = Unsigned; saturate = 1'b0;
        cyc();
        chk_state("wrap", 8'hFA, 2'b01, 1'b1, 2'b11, 2'd2);

        // Backpressure: held word must not change, new word must wait
        din[0] = 8'h12; din[1] = 8'h34; out_ready = 1'b0;
        #1;
        chk("bp.in_ready0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            sign     = (i == 1) ? Signed : Unsigned;
            saturate = (i == 1);
            cyc();
            chk_state("bp_hold", 8'hFA, 2'b01, 1'b1, 2'b11, 2'd2);
            chk("bp_hold.in_ready", 32'(in_ready), 32'd0);
        end
        sign = Unsigned; saturate = 1'b0; out_ready = 1'b1;
        #1;
        chk("bp.in_ready1", 32'(in_ready), 32'd1);
        cyc();
        chk_state("bp_new", 8'h42, 2'b11, 1'b1, 2'b11, 2'd3);
        in_valid = 1'b0;
        cyc();
        chk_state("bp_drain", 8'h42, 2'b11, 1'b0, 2'b11, 2'd3);

        // Reset while a word is held under backpressure
        din[0] = 8'h80; din[1] = 8'h00; in_valid = 1'b1; out_ready = 1'b0;
        cyc();
        chk_state("mid_acc", 8'h00, 2'b01, 1'b1, 2'b11, 2'd3);
        in_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk_state("mid_rst", 8'h00, 2'b00, 1'b0, 2'b00, 2'd0);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("mid_rst.no_handoff", 32'(out_valid), 32'd0);

        // Saturating counter: five overflowing words back to back
        din[0] = 8'h80; din[1] = 8'h00; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("cnt.count", 32'(ovf_count), 32'(cnt_exp[i]));
            chk("cnt.valid", 32'(out_valid), 32'd1);
        end
        chk("cnt.sticky", 32'(ovf_sticky), 32'(2'b01));

        // Clear coinciding with an overflowing accept on lane 1 only
        din[0] = 8'h00; din[1] = 8'hFF; clear = 1'b1;
        cyc();
        chk_state("clear", 8'hF0, 2'b10, 1'b1, 2'b10, 2'd1);
        clear = 1'b0; in_valid = 1'b0;
        cyc();
        chk_state("idle", 8'hF0, 2'b10, 1'b0, 2'b10, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
